// File: rtl/unpacker_arb.sv
// Round-robin arbiter that locks one requester onto a shared unpacker for a whole packet.
// Optional watchdog release is compiled in when UNPACKER_ARB_TMO_EN is defined.
module unpacker_arb #(
  parameter int N_PORTS = 4,
  parameter int TMO_CYC = 64
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_PORTS-1:0]      req_val,
  input  logic [N_PORTS-1:0]      req_sop,
  input  logic [N_PORTS-1:0]      req_eop,
  input  logic [N_PORTS*8-1:0]    req_vbc,
  input  logic [N_PORTS*1280-1:0] req_data,
  output logic [N_PORTS-1:0]      req_ready,
  output logic                    val,
  output logic                    sop,
  output logic                    eop,
  output logic [7:0]              vbc,
  output logic [1279:0]           data,
  input  logic                    ready,
  output logic [N_PORTS-1:0]      grant,
  output logic                    busy,
  output logic                    err
);

  localparam int DW = 1280;
  localparam int PW = $clog2(N_PORTS);
  localparam int SW = PW + 1;

  typedef enum logic {ARB = 1'b0, LOCK = 1'b1} state_t;

  state_t             state_q;
  logic [N_PORTS-1:0] grant_q;
  logic [N_PORTS-1:0] win_d;
  logic [N_PORTS-1:0] cand;
  logic [PW-1:0]      rr_ptr_q;
  logic [PW-1:0]      g_idx;
  logic [PW-1:0]      next_ptr;
  logic [PW-1:0]      arb_idx;
  logic [SW-1:0]      arb_sum;
  logic               arb_found;
  logic               err_q;
  logic               first_q;
  logic               xfer;
  logic               tmo_hit;

  // Handshake: a beat moves on any edge where val && ready. req_ready of the
  // granted port mirrors ready; grant_q is zero in ARB, so everything is quiet there.
  always_comb begin
    val   = 1'b0;
    sop   = 1'b0;
    eop   = 1'b0;
    vbc   = '0;
    data  = '0;
    g_idx = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      if (grant_q[i]) begin
        val   = req_val[i];
        sop   = req_sop[i];
        eop   = req_eop[i];
        vbc   = req_vbc[8*i +: 8];
        data  = req_data[DW*i +: DW];
        g_idx = PW'(i);
      end
    end
  end

  assign req_ready = grant_q & {N_PORTS{ready}};
  assign xfer      = val & ready;
  assign next_ptr  = (int'(g_idx) == N_PORTS - 1) ? '0 : g_idx + 1'b1;

  // First start-of-packet candidate at or after rr_ptr_q, wrapping downward to 0.
  always_comb begin
    cand      = req_val & req_sop;
    win_d     = '0;
    arb_found = 1'b0;
    arb_sum   = '0;
    arb_idx   = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      arb_sum = {1'b0, rr_ptr_q} + SW'(i);
      if (arb_sum >= SW'(N_PORTS)) arb_sum = arb_sum - SW'(N_PORTS);
      arb_idx = arb_sum[PW-1:0];
      if (!arb_found && cand[arb_idx]) begin
        win_d[arb_idx] = 1'b1;
        arb_found      = 1'b1;
      end
    end
  end

`ifdef UNPACKER_ARB_TMO_EN
  localparam int CW = $clog2(TMO_CYC + 1);
  logic [CW-1:0] wd_q;

  // Counts locked cycles in which the owner shows no beat; any transfer restarts it.
  assign tmo_hit = (state_q == LOCK) && !val && (wd_q == CW'(TMO_CYC - 1));

  always_ff @(posedge clk) begin
    if (reset || state_q != LOCK || xfer) wd_q <= '0;
    else if (!val)                        wd_q <= wd_q + 1'b1;
  end
`else
  assign tmo_hit = (TMO_CYC < 0);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ARB;
      grant_q  <= '0;
      rr_ptr_q <= '0;
      err_q    <= 1'b0;
      first_q  <= 1'b0;
    end else begin
      case (state_q)
        ARB: begin
          if (|win_d) begin
            grant_q <= win_d;
            first_q <= 1'b1;
            state_q <= LOCK;
          end
        end
        LOCK: begin
          if (xfer) begin
            first_q <= 1'b0;
            // A second sop inside a locked packet is flagged but still forwarded.
            if (sop && !first_q) err_q <= 1'b1;
          end
          if ((xfer && eop) || tmo_hit) begin
            state_q  <= ARB;
            grant_q  <= '0;
            rr_ptr_q <= next_ptr;
          end
          if (tmo_hit) err_q <= 1'b1;
        end
        default: state_q <= ARB;
      endcase
    end
  end

  assign grant = grant_q;
  assign busy  = (state_q == LOCK);
  assign err   = err_q;

endmodule

// File: tb/tb_unpacker_arb.sv
// Self-checking bench for unpacker_arb: per-port beat drivers, a transfer scoreboard and scenario tasks.
// The watchdog scenario runs only when UNPACKER_ARB_TMO_EN is defined.
module tb_unpacker_arb;

  localparam int NP = 4;
  localparam int DW = 1280;
  localparam int BW = DW + 10;
  localparam int EW = BW + 3;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [NP-1:0]     req_val = '0;
  logic [NP-1:0]     req_sop = '0;
  logic [NP-1:0]     req_eop = '0;
  logic [NP*8-1:0]   req_vbc = '0;
  logic [NP*DW-1:0]  req_data = '0;
  logic [NP-1:0]     req_ready;
  logic              val;
  logic              sop;
  logic              eop;
  logic [7:0]        vbc;
  logic [DW-1:0]     data;
  logic              ready = 1'b0;
  logic [NP-1:0]     grant;
  logic              busy;
  logic              err;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

  logic [EW-1:0] exp_q[$];
  int            xfer_cyc[$];
  logic [BW-1:0] pq[NP][$];
  logic [NP-1:0] acc = '0;
  logic [NP-1:0] kill = '0;

  logic [EW-1:0] mon_got;
  logic [EW-1:0] mon_want;
  logic [2:0]    mon_port;

  unpacker_arb #(.N_PORTS(NP), .TMO_CYC(64)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_val   (req_val),
    .req_sop   (req_sop),
    .req_eop   (req_eop),
    .req_vbc   (req_vbc),
    .req_data  (req_data),
    .req_ready (req_ready),
    .val       (val),
    .sop       (sop),
    .eop       (eop),
    .vbc       (vbc),
    .data      (data),
    .ready     (ready),
    .grant     (grant),
    .busy      (busy),
    .err       (err)
  );

  // Clock / cycle counter / run limit
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, compared=%0d", n_cmp);
    $fatal(1, "run limit reached");
  end

  // Drivers: each port holds its beat until accepted, then moves to its next queued beat.
  task automatic drive_beat(input int p, input logic [BW-1:0] b);
    req_val[p]            = 1'b1;
    req_sop[p]            = b[BW-1];
    req_eop[p]            = b[BW-2];
    req_vbc[8*p +: 8]     = b[DW+7:DW];
    req_data[DW*p +: DW]  = b[DW-1:0];
  endtask

  task automatic drive_idle(input int p);
    req_val[p]           = 1'b0;
    req_sop[p]           = 1'b0;
    req_eop[p]           = 1'b0;
    req_vbc[8*p +: 8]    = '0;
    req_data[DW*p +: DW] = '0;
  endtask

  always @(negedge clk) acc = req_val & req_ready;

  always @(posedge clk) begin
    #1;
    for (int p = 0; p < NP; p++) begin
      if (kill[p]) begin
        pq[p].delete();
        kill[p] = 1'b0;
        drive_idle(p);
      end else if (acc[p] || !req_val[p]) begin
        if (pq[p].size() != 0) drive_beat(p, pq[p].pop_front());
        else drive_idle(p);
      end
    end
  end

  function automatic logic [BW-1:0] mk_beat(input logic s, input logic e, input logic [7:0] v);
    logic [DW-1:0] d;
    for (int k = 0; k < DW/32; k++) d[32*k +: 32] = $urandom();
    return {s, e, v, d};
  endfunction

  // Queues n beats on port p; the first n_exp are expected at the unpacker, in call order.
  task automatic queue_pkt(input int p, input int n, input bit bad_sop, input int n_exp, input bit trunc);
    logic [BW-1:0] b;
    logic          s;
    logic          e;
    logic [7:0]    v;
    for (int k = 0; k < n; k++) begin
      s = (k == 0) || (bad_sop && k == 1);
      e = (k == n - 1) && !trunc;
      v = (k == 1) ? 8'd0 : 8'($urandom_range(1, 255));
      b = mk_beat(s, e, v);
      pq[p].push_back(b);
      if (k < n_exp) exp_q.push_back({3'(p), b});
    end
  endtask

  // Scoreboard: every transfer is popped against the expected queue.
  always @(negedge clk) begin
    if (val && ready) begin
      mon_port = '0;
      for (int p = 0; p < NP; p++) if (grant[p]) mon_port = 3'(p);
      mon_got = {mon_port, sop, eop, vbc, data};
      xfer_cyc.push_back(cyc);
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL scoreboard_extra: unexpected beat port=%0d sop=%0b eop=%0b vbc=%0d, want none",
                 mon_port, sop, eop, vbc);
      end else begin
        mon_want = exp_q.pop_front();
        if (mon_got !== mon_want) begin
          n_err++;
          $display("FAIL scoreboard_beat: got port=%0d sop=%0b eop=%0b vbc=%0d data_lo=%h, want port=%0d sop=%0b eop=%0b vbc=%0d data_lo=%h",
                   mon_got[EW-1 -: 3], mon_got[BW-1], mon_got[BW-2], mon_got[DW+7:DW], mon_got[63:0],
                   mon_want[EW-1 -: 3], mon_want[BW-1], mon_want[BW-2], mon_want[DW+7:DW], mon_want[63:0]);
        end
      end
    end
  end

  task automatic do_reset;
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
    @(negedge clk);
  endtask

  task automatic wait_drain(input int budget, input string name);
    int c;
    c = 0;
    while ((exp_q.size() != 0 || busy || (|req_val) ||
            pq[0].size() != 0 || pq[1].size() != 0 || pq[2].size() != 0 || pq[3].size() != 0)
           && c < budget) begin
      @(negedge clk);
      c++;
    end
    n_cmp++;
    if (c >= budget) begin
      n_err++;
      $display("FAIL %s_drain: still busy after %0d cycles, %0d beats outstanding, want idle", name, c, exp_q.size());
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    ready = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    n_cmp++; if (grant !== '0) begin n_err++; $display("FAIL reset_grant: got %b want 0000", grant); end
    n_cmp++; if ({busy, err} !== 2'b00) begin n_err++; $display("FAIL reset_busy_err: got %b want 00", {busy, err}); end
    n_cmp++; if ({val, sop, eop} !== 3'b000) begin n_err++; $display("FAIL reset_val: got %b want 000", {val, sop, eop}); end
    reset = 1'b0;
    @(negedge clk);
    n_cmp++; if (req_ready !== '0) begin n_err++; $display("FAIL post_reset_req_ready: got %b want 0000", req_ready); end
    n_cmp++; if (vbc !== 8'd0 || data !== '0) begin n_err++; $display("FAIL post_reset_vbc_data: got vbc=%0d data_lo=%h want 0", vbc, data[63:0]); end
    n_cmp++; if ({grant, busy, err, val} !== 7'b0) begin n_err++; $display("FAIL post_reset_outputs: got %b want 0", {grant, busy, err, val}); end
  endtask

  task automatic test_two_ports;
    queue_pkt(0, 1, 1'b0, 1, 1'b0);
    queue_pkt(2, 1, 1'b0, 1, 1'b0);
    step();
    n_cmp++; if ({grant, busy, val, req_ready} !== 10'b0) begin n_err++; $display("FAIL arb_cycle_quiet: got %b want 0", {grant, busy, val, req_ready}); end
    step();
    n_cmp++; if (grant !== 4'b0001) begin n_err++; $display("FAIL first_grant: got %b want 0001", grant); end
    n_cmp++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL first_req_ready: got %b want 0001", req_ready); end
    wait_drain(40, "two_ports");
    // rr_ptr should now be 3, so port 3 beats port 1.
    queue_pkt(3, 1, 1'b0, 1, 1'b0);
    queue_pkt(1, 1, 1'b0, 1, 1'b0);
    wait_drain(40, "rr_after_port2");
  endtask

  task automatic test_ready_toggle;
    bit rs[6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    bit eb;
    xfer_cyc.delete();
    queue_pkt(1, 3, 1'b0, 3, 1'b0);
    for (int c = 0; c < 6; c++) begin
      @(posedge clk);
      #1;
      ready = rs[c];
      @(negedge clk);
      eb = (c >= 1 && c <= 4);
      n_cmp++; if (busy !== eb) begin n_err++; $display("FAIL toggle_busy_c%0d: got %b want %b", c, busy, eb); end
      n_cmp++;
      if (req_ready !== (eb ? {2'b00, rs[c], 1'b0} : 4'b0000)) begin
        n_err++; $display("FAIL toggle_req_ready_c%0d: got %b want %b", c, req_ready, eb ? {2'b00, rs[c], 1'b0} : 4'b0000);
      end
    end
    ready = 1'b1;
    wait_drain(20, "ready_toggle");
    n_cmp++; if (xfer_cyc.size() != 3) begin n_err++; $display("FAIL toggle_xfers: got %0d want 3", xfer_cyc.size()); end
  endtask

  task automatic test_back_to_back;
    do_reset();
    xfer_cyc.delete();
    for (int p = 0; p < NP; p++) queue_pkt(p, 1, 1'b0, 1, 1'b0);
    queue_pkt(0, 1, 1'b0, 1, 1'b0);
    wait_drain(60, "back_to_back");
    n_cmp++; if (xfer_cyc.size() != 5) begin n_err++; $display("FAIL b2b_count: got %0d want 5", xfer_cyc.size()); end
    for (int k = 1; k < xfer_cyc.size(); k++) begin
      n_cmp++;
      if (xfer_cyc[k] - xfer_cyc[k-1] != 2) begin
        n_err++; $display("FAIL b2b_spacing_%0d: got %0d cycles want 2", k, xfer_cyc[k] - xfer_cyc[k-1]);
      end
    end
  endtask

  task automatic test_sop_err;
    n_cmp++; if (err !== 1'b0) begin n_err++; $display("FAIL err_before: got %b want 0", err); end
    queue_pkt(3, 3, 1'b1, 3, 1'b0);
    for (int c = 0; c < 5; c++) begin
      step();
      if (c >= 1 && c <= 3) begin
        n_cmp++; if (grant !== 4'b1000) begin n_err++; $display("FAIL sop_err_lock_c%0d: got %b want 1000", c, grant); end
      end
      if (c == 3) begin
        n_cmp++; if (err !== 1'b1) begin n_err++; $display("FAIL sop_err_set: got %b want 1", err); end
      end
      if (c == 4) begin
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL sop_err_release: got busy=%b want 0", busy); end
      end
    end
    wait_drain(20, "sop_err");
    queue_pkt(0, 1, 1'b0, 1, 1'b0);
    wait_drain(20, "sop_err_clean");
    n_cmp++; if (err !== 1'b1) begin n_err++; $display("FAIL err_sticky: got %b want 1", err); end
    do_reset();
    n_cmp++; if (err !== 1'b0) begin n_err++; $display("FAIL err_cleared: got %b want 0", err); end
  endtask

  task automatic test_mid_reset;
    queue_pkt(1, 1, 1'b0, 1, 1'b0);
    wait_drain(20, "mid_reset_pre");
    queue_pkt(2, 3, 1'b0, 1, 1'b0);
    step();
    step();
    n_cmp++; if (grant !== 4'b0100) begin n_err++; $display("FAIL mid_reset_lock: got %b want 0100", grant); end
    @(posedge clk);
    #1;
    reset = 1'b1;
    ready = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    ready = 1'b1;
    @(negedge clk);
    n_cmp++; if ({grant, val, busy} !== 6'b0) begin n_err++; $display("FAIL mid_reset_after: got grant=%b val=%b busy=%b want 0", grant, val, busy); end
    n_cmp++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL mid_reset_req_ready: got %b want 0000", req_ready); end
    kill[2] = 1'b1;
    wait_drain(20, "mid_reset_flush");
    // rr_ptr back at 0: port 0 must beat port 3.
    queue_pkt(0, 1, 1'b0, 1, 1'b0);
    queue_pkt(3, 1, 1'b0, 1, 1'b0);
    wait_drain(20, "mid_reset_rr");
  endtask

`ifdef UNPACKER_ARB_TMO_EN
  task automatic test_timeout;
    n_cmp++; if (err !== 1'b0) begin n_err++; $display("FAIL tmo_err_before: got %b want 0", err); end
    queue_pkt(1, 1, 1'b0, 1, 1'b1);
    queue_pkt(2, 1, 1'b0, 1, 1'b0);
    for (int c = 0; c < 68; c++) begin
      step();
      if (c == 1) begin
        n_cmp++; if (grant !== 4'b0010) begin n_err++; $display("FAIL tmo_grant: got %b want 0010", grant); end
      end
      if (c == 65) begin
        n_cmp++; if ({busy, err} !== 2'b10) begin n_err++; $display("FAIL tmo_hold: got busy,err=%b want 10", {busy, err}); end
      end
      if (c == 66) begin
        n_cmp++; if ({busy, err} !== 2'b01) begin n_err++; $display("FAIL tmo_release: got busy,err=%b want 01", {busy, err}); end
      end
      if (c == 67) begin
        n_cmp++; if (grant !== 4'b0100) begin n_err++; $display("FAIL tmo_next_grant: got %b want 0100", grant); end
      end
    end
    wait_drain(20, "timeout");
  endtask
`else
  task automatic test_lock_hold;
    queue_pkt(1, 1, 1'b0, 1, 1'b1);
    for (int c = 0; c < 80; c++) begin
      step();
      if (c == 1 || c == 40 || c == 79) begin
        n_cmp++;
        if ({grant, busy, err} !== 6'b001010) begin
          n_err++; $display("FAIL lock_hold_c%0d: got grant=%b busy=%b err=%b want 0010 1 0", c, grant, busy, err);
        end
      end
    end
    pq[1].push_back(mk_beat(1'b0, 1'b1, 8'd5));
    exp_q.push_back({3'd1, pq[1][0]});
    wait_drain(20, "lock_hold");
    n_cmp++; if (err !== 1'b0) begin n_err++; $display("FAIL lock_hold_err: got %b want 0", err); end
  endtask
`endif

  initial begin
    test_reset();
    test_two_ports();
    test_ready_toggle();
    test_back_to_back();
    test_sop_err();
    test_mid_reset();
`ifdef UNPACKER_ARB_TMO_EN
    test_timeout();
`else
    test_lock_hold();
`endif
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++; $display("FAIL final_queue: got %0d beats outstanding want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/unpacker_arb.md
UNPACKER_ARB -- requirements
Module: unpacker_arb

Interface
REQ-001 The block SHALL have parameter N_PORTS, default 4: number of requesters sharing one unpacker; legal range 2..8.
REQ-002 The block SHALL have parameter TMO_CYC, default 64: watchdog limit in cycles; used only when the Configuration macro is defined.
REQ-003 The block SHALL have ports, in this order:
- clk  in  1  single clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- req_val  in  N_PORTS  per-port beat valid.
- req_sop  in  N_PORTS  per-port start of packet.
- req_eop  in  N_PORTS  per-port end of packet.
- req_vbc  in  N_PORTS*8  per-port valid byte count, port i at [8i+:8].
- req_data  in  N_PORTS*1280  per-port beat data, port i at [1280i+:1280].
- req_ready  out  N_PORTS  per-port beat accepted when req_val and req_ready are both high.
- val  out  1  beat valid to unpacker.
- sop  out  1  start of packet to unpacker.
- eop  out  1  end of packet to unpacker.
- vbc  out  8  valid byte count to unpacker.
- data  out  1280  beat data to unpacker.
- ready  in  1  unpacker ready; a beat transfers when val and ready are both high.
- grant  out  N_PORTS  one-hot owner of the unpacker; all zero when unowned.
- busy  out  1  high while a packet is locked to a port.
- err  out  1  sticky protocol error flag.

Function
REQ-004 The block SHALL use a two-state FSM: ARB and LOCK.
REQ-005 In ARB, candidates SHALL be ports with req_val and req_sop both high; the winner SHALL be the first candidate at or after rr_ptr, searching upward with wrap from N_PORTS-1 to 0.
REQ-006 With at least one candidate in ARB, the block SHALL register the one-hot grant and go to LOCK on the next edge; no beat transfers in an ARB cycle.
REQ-007 With no candidate in ARB, the block SHALL stay in ARB with grant all zero.
REQ-008 In LOCK, val/sop/eop/vbc/data SHALL be a combinational copy of the granted port's req_* signals (zero added latency).
REQ-009 In LOCK, req_ready[g] SHALL equal ready for the granted port g; every other req_ready bit SHALL be 0.
REQ-010 In ARB, all req_ready bits SHALL be 0 and val/sop/eop SHALL be 0; vbc and data SHALL be 0.
REQ-011 When a beat with eop transfers in LOCK, the block SHALL go to ARB, clear grant, and set rr_ptr to (g+1) mod N_PORTS on the same edge.
REQ-012 A single-beat packet (sop and eop both high) SHALL lock and release exactly as REQ-006 and REQ-011, taking 2 cycles when ready is high.
REQ-013 In LOCK, a transferred beat with sop high that is not the packet's first beat SHALL set err; the beat SHALL still be forwarded and the lock kept.
REQ-014 Beats with vbc equal to 0 SHALL be forwarded unchanged; the arbiter SHALL NOT inspect vbc.
REQ-015 busy SHALL equal (state == LOCK).
REQ-016 err SHALL stay set until reset.

Reset
REQ-017 While reset is high at a clk edge, the block SHALL load state=ARB, grant=0, rr_ptr=0, err=0 and the watchdog count=0; this SHALL also apply mid-packet, with no further beats forwarded.
REQ-018 After reset, all outputs SHALL be 0 until the first grant.

Configuration
REQ-019 With UNPACKER_ARB_TMO_EN defined, a counter SHALL reset on every transfer and count LOCK cycles with req_val[g] low; on reaching TMO_CYC, the block SHALL set err, release to ARB and advance rr_ptr as in REQ-011.
REQ-020 Without UNPACKER_ARB_TMO_EN, no watchdog logic SHALL exist and LOCK SHALL persist until eop transfers.

Verification
REQ-021 Ports 0 and 2 present sop at the same time, ready=1, after reset -> port 0 is granted first, then port 2; rr_ptr=3 after port 2's eop.
REQ-022 Port 1 sends a 3-beat packet with ready toggling 1,0,1,1 -> 3 transfers, req_ready[1] tracks ready, busy drops the cycle after the eop transfer.
REQ-023 All 4 ports request back-to-back single-beat packets -> grant order 0,1,2,3,0 with each packet taking 2 cycles.
REQ-024 Granted port 3 asserts sop on its second beat -> err=1, packet completes, err stays 1 until reset.
REQ-025 Reset asserted during the second beat of a locked packet -> next cycle grant=0, val=0, busy=0, rr_ptr=0.
REQ-026 With UNPACKER_ARB_TMO_EN defined and TMO_CYC=64, granted port drops req_val mid-packet -> release after 64 idle cycles, err=1, next port granted.
